led_pattern_ctrl: RTL and testbench
===================================

# led_pattern_ctrl

Multi-mode LED driver behind the AXI4-Lite slave register interface. It takes the slave's write strobe, word address and write data, holds a small bank of control registers, and drives a parametrised LED bus. Each LED is either static, blinking, PWM-dimmed, or dimmed and blinking. It is the successor to the single-register LED latch and sits in the IP's user-logic slot next to the AXI slave wrapper.

## Interface
Parameters:
- LED_WIDTH, default 8: number of LED outputs, 1..32.
- PRESCALE_WIDTH, default 16: width of the prescaler reload register, 1..32.

Ports:
- S_AXI_ACLK  in  1  sole clock; all state is updated on the rising edge.
- S_AXI_ARESETN  in  1  reset; asynchronous, active-low.
- slv_reg_wren  in  1  one-cycle write strobe from the slave.
- axi_awaddr  in  3  word index of the register being written.
- S_AXI_WDATA  in  32  write data; unused upper bits are ignored.
- LED  out  LED_WIDTH  registered LED drive.

## Operation
Register map (word index, field, reset value):
- 0 LED_VAL[LED_WIDTH-1:0], 0: base on/off pattern.
- 1 MODE[1:0], 0: 00 static, 01 blink, 10 PWM, 11 PWM gated by blink.
- 2 PRESCALE[PRESCALE_WIDTH-1:0], 0: a tick fires every PRESCALE+1 clocks.
- 3 DUTY[7:0], 0: PWM on-count out of 256.
- 4 BLINK[7:0], 0: blink phase toggles every BLINK+1 PWM periods.
- 5 CH_MASK[LED_WIDTH-1:0], all ones: present only with LED_CH_MASK_EN.
- Writes to any other index are ignored, with no side effects.

Counters:
- presc_cnt counts 0..PRESCALE. tick = (presc_cnt == PRESCALE); on a tick, presc_cnt returns to 0.
- pwm_cnt is 8 bits and increments on each tick, wrapping 255 to 0. pwm_wrap = tick && pwm_cnt == 255.
- blink_cnt is 8 bits and increments on each pwm_wrap. When pwm_wrap && blink_cnt == BLINK: phase toggles and blink_cnt returns to 0.
- pwm_on = (pwm_cnt < DUTY). DUTY 0 gives always off; 255 gives on for 255 of 256.
- phase = 0 means on.

Gate by MODE:
- 00: gate = 1.
- 01: gate = ~phase.
- 10: gate = pwm_on.
- 11: gate = pwm_on & ~phase.

Output:
- Next LED = LED_VAL & {LED_WIDTH{gate}}.
- With the mask, each bit i uses gate only where CH_MASK[i] = 1; otherwise that bit is LED_VAL[i].

Restart rule: a write to MODE, PRESCALE, DUTY or BLINK clears presc_cnt, pwm_cnt, blink_cnt and phase in the same edge. A write to LED_VAL or CH_MASK does not disturb the counters.

## Timing
- Reset: asynchronous assertion immediately clears all registers and counters to their reset values and sets LED = 0. Release is synchronous to S_AXI_ACLK.
- Reset asserted mid-pattern: LED goes to 0 at once. After release the block is in static mode with LED_VAL = 0.
- Write: a write accepted at edge N updates the register at edge N, and LED reflects it at edge N+1 (one-cycle latency).
- Counters run continuously. In static mode their value is don't-care, but they still count.
- PWM period = 256·(PRESCALE+1) clocks. Blink half-period = (BLINK+1)·PWM period.
- A write on the same edge as a tick or wrap: the write wins. Counters are cleared and no toggle occurs.
- PRESCALE = 0: tick fires every clock.

## Configuration
- LED_CH_MASK_EN defined:
  - Register 5 CH_MASK exists and resets to all ones.
  - Masked-off channels (bit = 0) show LED_VAL statically regardless of MODE.
- LED_CH_MASK_EN undefined:
  - No mask storage exists; every channel follows MODE.
  - A write to index 5 is ignored like any unmapped index.

## Test plan
- Static: reset, write LED_VAL = 0xA5 at index 0 -> LED = 0xA5 one clock later, stable thereafter. LED = 0 throughout reset.
- PWM duty: LED_VAL = 0xFF, PRESCALE = 0, DUTY = 64, MODE = 2 -> LED = 0xFF for exactly 64 of every 256 clocks, starting the clock after the MODE write. DUTY = 0 -> LED stays 0.
- Blink: LED_VAL = 0x0F, PRESCALE = 1, BLINK = 1, MODE = 1 -> LED alternates 0x0F / 0x00 every 1024 clocks, starting with 0x0F.
- Restart and collision: write DUTY on a clock where pwm_wrap would fire -> counters are 0 the next cycle and phase is unchanged. A write to index 7 has no effect on any output.
- Async reset mid-blink: assert S_AXI_ARESETN = 0 between edges -> LED = 0 before the next edge. After release, MODE reads as static and LED stays 0.
- Mask (LED_CH_MASK_EN): LED_VAL = 0xFF, CH_MASK = 0xF0, MODE = 1 -> LED alternates 0xFF / 0x0F. Without the macro, the same writes give 0xFF / 0x00.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// Multi-mode LED driver (static / blink / PWM / PWM+blink) behind an AXI4-Lite register write port.
// Optional per-channel bypass mask enabled by defining LED_CH_MASK_EN.
module led_pattern_ctrl #(
    parameter int LED_WIDTH      = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    input  logic                 slv_reg_wren,
    input  logic [2:0]           axi_awaddr,
    input  logic [31:0]          S_AXI_WDATA,
    output logic [LED_WIDTH-1:0] LED
);

    typedef enum logic [1:0] {
        MODE_STATIC    = 2'b00,
        MODE_BLINK     = 2'b01,
        MODE_PWM       = 2'b10,
        MODE_PWM_BLINK = 2'b11
    } mode_e;

    logic [LED_WIDTH-1:0]      led_val_q, led_val_d;
    mode_e                     mode_q, mode_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [7:0]                duty_q, duty_d;
    logic [7:0]                blink_q, blink_d;
    logic [PRESCALE_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic [7:0]                pwm_cnt_q, pwm_cnt_d;
    logic [7:0]                blink_cnt_q, blink_cnt_d;
    logic                      phase_q, phase_d;
    logic [LED_WIDTH-1:0]      led_q, led_d;

    logic                      tick, pwm_wrap, pwm_on, gate, restart;
    logic [LED_WIDTH-1:0]      gate_vec;
    logic                      unused_wdata;

    assign unused_wdata = ^S_AXI_WDATA;

    // Any timing-parameter write restarts the pattern from a known point.
    assign restart  = slv_reg_wren && (axi_awaddr inside {3'd1, 3'd2, 3'd3, 3'd4});
    assign tick     = (presc_cnt_q == prescale_q);
    assign pwm_wrap = tick && (pwm_cnt_q == 8'hFF);
    assign pwm_on   = (pwm_cnt_q < duty_q);

    always_comb begin
        led_val_d  = led_val_q;
        mode_d     = mode_q;
        prescale_d = prescale_q;
        duty_d     = duty_q;
        blink_d    = blink_q;
        if (slv_reg_wren) begin
            case (axi_awaddr)
                3'd0:    led_val_d  = S_AXI_WDATA[LED_WIDTH-1:0];
                3'd1:    mode_d     = mode_e'(S_AXI_WDATA[1:0]);
                3'd2:    prescale_d = S_AXI_WDATA[PRESCALE_WIDTH-1:0];
                3'd3:    duty_d     = S_AXI_WDATA[7:0];
                3'd4:    blink_d    = S_AXI_WDATA[7:0];
                default: ;
            endcase
        end
    end

    // A restart takes priority over a coincident tick or wrap, so no toggle leaks through.
    always_comb begin
        presc_cnt_d = presc_cnt_q;
        pwm_cnt_d   = pwm_cnt_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (restart) begin
            presc_cnt_d = '0;
            pwm_cnt_d   = 8'd0;
            blink_cnt_d = 8'd0;
            phase_d     = 1'b0;
        end else begin
            if (tick) begin
                presc_cnt_d = '0;
                pwm_cnt_d   = pwm_cnt_q + 8'd1;
            end else begin
                presc_cnt_d = presc_cnt_q + PRESCALE_WIDTH'(1);
            end
            if (pwm_wrap) begin
                if (blink_cnt_q == blink_q) begin
                    blink_cnt_d = 8'd0;
                    phase_d     = ~phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 8'd1;
                end
            end
        end
    end

    always_comb begin
        gate = 1'b1;
        case (mode_q)
            MODE_STATIC:    gate = 1'b1;
            MODE_BLINK:     gate = ~phase_q;
            MODE_PWM:       gate = pwm_on;
            MODE_PWM_BLINK: gate = pwm_on & ~phase_q;
            default:        gate = 1'b1;
        endcase
    end

`ifdef LED_CH_MASK_EN
    logic [LED_WIDTH-1:0] ch_mask_q, ch_mask_d;

    always_comb begin
        ch_mask_d = ch_mask_q;
        if (slv_reg_wren && axi_awaddr == 3'd5) begin
            ch_mask_d = S_AXI_WDATA[LED_WIDTH-1:0];
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ch_mask_q <= '1;
        end else begin
            ch_mask_q <= ch_mask_d;
        end
    end

    // Masked-off channels bypass the gate and show LED_VAL directly.
    assign gate_vec = {LED_WIDTH{gate}} | ~ch_mask_q;
`else
    assign gate_vec = {LED_WIDTH{gate}};
`endif

    assign led_d = led_val_q & gate_vec;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            led_val_q   <= '0;
            mode_q      <= MODE_STATIC;
            prescale_q  <= '0;
            duty_q      <= 8'd0;
            blink_q     <= 8'd0;
            presc_cnt_q <= '0;
            pwm_cnt_q   <= 8'd0;
            blink_cnt_q <= 8'd0;
            phase_q     <= 1'b0;
            led_q       <= '0;
        end else begin
            led_val_q   <= led_val_d;
            mode_q      <= mode_d;
            prescale_q  <= prescale_d;
            duty_q      <= duty_d;
            blink_q     <= blink_d;
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
        end
    end

    assign LED = led_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl: register-effect vector table plus
// multi-cycle PWM, blink, collision, async-reset and mask sequences, checked through a scoreboard queue.
module tb_led_pattern_ctrl;

    logic        clock;
    logic        resetN;
    logic        wren;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  led;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [7:0] exp;
        bit         care;
    } sbEntry_t;

    typedef struct {
        string       name;
        bit          wr;
        logic [2:0]  a;
        logic [31:0] d;
        logic [7:0]  exp;
    } vec_t;

    sbEntry_t sbQ[$];
    vec_t     vecs[8];

    led_pattern_ctrl #(.LED_WIDTH(8), .PRESCALE_WIDTH(16)) dut (
        .S_AXI_ACLK   (clock),
        .S_AXI_ARESETN(resetN),
        .slv_reg_wren (wren),
        .axi_awaddr   (addr),
        .S_AXI_WDATA  (wdata),
        .LED          (led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Each negedge consumes the expectation for the LED value produced by the preceding posedge.
    always @(negedge clock) begin
        if (sbQ.size() > 0) begin
            sbEntry_t e;
            e = sbQ.pop_front();
            if (e.care) begin
                checks++;
                if (led !== e.exp) begin
                    errors++;
                    $display("[TB] FAIL %s: LED=%h expected %h at %0t", e.name, led, e.exp, $time);
                end
            end
        end
    end

    task automatic pushExp(input string name, input logic [7:0] exp, input bit care);
        sbEntry_t e;
        e.name = name;
        e.exp  = exp;
        e.care = care;
        sbQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
        @(posedge clock);
        #1;
        wren  = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clock);
        #1;
        wren  = 1'b0;
        addr  = 3'd0;
        wdata = 32'd0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sbQ.size() != 0 && n < 5000) begin
            @(posedge clock);
            n++;
        end
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: %0d entries left, required 0", sbQ.size());
            sbQ.delete();
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp);
        checks++;
        if (led !== exp) begin
            errors++;
            $display("[TB] FAIL %s: LED=%h expected %h at %0t", name, led, exp, $time);
        end
    endtask

    initial begin
        logic [7:0] prevExp;
        vecs[0] = '{"led_val_a5",   1'b1, 3'd0, 32'h0000_00A5, 8'hA5};
        vecs[1] = '{"unmapped_7",   1'b1, 3'd7, 32'hFFFF_FFFF, 8'hA5};
        vecs[2] = '{"unmapped_6",   1'b1, 3'd6, 32'h0000_0000, 8'hA5};
        vecs[3] = '{"led_val_3c",   1'b1, 3'd0, 32'h0000_003C, 8'h3C};
        vecs[4] = '{"idx5_static",  1'b1, 3'd5, 32'h0000_0000, 8'h3C};
        vecs[5] = '{"upper_ignore", 1'b1, 3'd0, 32'hFFFF_FF81, 8'h81};
        vecs[6] = '{"idle_hold",    1'b0, 3'd0, 32'h0000_0000, 8'h81};
        vecs[7] = '{"mode_upper",   1'b1, 3'd1, 32'h0000_0004, 8'h81};

        resetN = 1'b0;
        wren   = 1'b0;
        addr   = 3'd0;
        wdata  = 32'd0;

        for (int i = 0; i < 5; i++) pushExp("in_reset", 8'h00, 1'b1);
        #52;
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) pushExp("post_reset", 8'h00, 1'b1);
        waitDrain();

        prevExp = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) applyStimulus(vecs[i].a, vecs[i].d);
            else begin
                @(posedge clock);
                #1;
            end
            pushExp({vecs[i].name, "_edgeN"}, prevExp, 1'b1);
            pushExp(vecs[i].name, vecs[i].exp, 1'b1);
            pushExp({vecs[i].name, "_hold"}, vecs[i].exp, 1'b1);
            waitDrain();
            prevExp = vecs[i].exp;
        end

        // PWM 64/256 starting the clock after the MODE write
        applyStimulus(3'd0, 32'hFF);
        applyStimulus(3'd2, 32'd0);
        applyStimulus(3'd3, 32'd64);
        applyStimulus(3'd1, 32'd2);
        pushExp("pwm64_edgeN", 8'h00, 1'b0);
        for (int k = 1; k <= 512; k++)
            pushExp("pwm64", (((k - 1) % 256) < 64) ? 8'hFF : 8'h00, 1'b1);
        waitDrain();

        // Mid-period DUTY write restarts the PWM counter from zero
        applyStimulus(3'd3, 32'd32);
        pushExp("pwm32_edgeN", 8'h00, 1'b0);
        for (int k = 1; k <= 300; k++)
            pushExp("pwm32_restart", (((k - 1) % 256) < 32) ? 8'hFF : 8'h00, 1'b1);
        waitDrain();

        applyStimulus(3'd3, 32'd0);
        pushExp("duty0_edgeN", 8'h00, 1'b0);
        for (int k = 1; k <= 300; k++) pushExp("duty0", 8'h00, 1'b1);
        waitDrain();

        // DUTY write lands on the edge where pwm_wrap would toggle the blink phase
        applyStimulus(3'd3, 32'd255);
        applyStimulus(3'd4, 32'd0);
        applyStimulus(3'd1, 32'd3);
        pushExp("coll_edgeM", 8'h00, 1'b0);
        for (int k = 1; k <= 255; k++) pushExp("coll_pre", 8'hFF, 1'b1);
        pushExp("coll_cnt255", 8'h00, 1'b1);
        repeat (254) @(posedge clock);
        applyStimulus(3'd3, 32'd200);
        for (int j = 0; j < 256; j++)
            pushExp("coll_post", (j < 200) ? 8'hFF : 8'h00, 1'b1);
        waitDrain();

        // Blink with PRESCALE=1, BLINK=1: 1024-clock half period
        applyStimulus(3'd0, 32'h0F);
        applyStimulus(3'd2, 32'd1);
        applyStimulus(3'd4, 32'd1);
        applyStimulus(3'd1, 32'd1);
        pushExp("blink_edgeN", 8'h00, 1'b0);
        for (int k = 1; k <= 2060; k++)
            pushExp("blink", ((((k - 1) / 1024) % 2) == 0) ? 8'h0F : 8'h00, 1'b1);
        waitDrain();

        // Asynchronous reset between edges while LED is lit
        #3;
        resetN = 1'b0;
        #1;
        checkOutput("async_reset_immediate", 8'h00);
        for (int i = 0; i < 3; i++) pushExp("reset_hold", 8'h00, 1'b1);
        waitDrain();
        resetN = 1'b1;
        for (int i = 0; i < 20; i++) pushExp("after_release", 8'h00, 1'b1);
        waitDrain();
        applyStimulus(3'd0, 32'h55);
        pushExp("static_after_reset_edgeN", 8'h00, 1'b1);
        for (int k = 1; k <= 600; k++) pushExp("static_after_reset", 8'h55, 1'b1);
        waitDrain();

        // Channel mask: upper nibble blinks, lower nibble static when the mask exists
        applyStimulus(3'd0, 32'hFF);
        applyStimulus(3'd5, 32'hF0);
        applyStimulus(3'd1, 32'd1);
        pushExp("mask_edgeN", 8'h00, 1'b0);
        for (int k = 1; k <= 256; k++) pushExp("mask_on", 8'hFF, 1'b1);
`ifdef LED_CH_MASK_EN
        for (int k = 1; k <= 256; k++) pushExp("mask_off", 8'h0F, 1'b1);
`else
        for (int k = 1; k <= 256; k++) pushExp("mask_off", 8'h00, 1'b1);
`endif
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
